// File: rtl/tmr_pkg.sv
// Shared types for the triple-modular-redundancy resync controller.
// Holds FSM states, replica indices and voter selectors.
package tmr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FATAL
   } state_e;

   typedef logic [1:0] repl_t;

   localparam repl_t REPL_A = 2'd0;
   localparam repl_t REPL_B = 2'd1;
   localparam repl_t REPL_C = 2'd2;

   localparam int VOTER_AO = 0;
   localparam int VOTER_KP = 1;
   localparam int VOTER_BN = 2;

   // Only meaningful when exactly one flag is set.
   function automatic repl_t flag_idx(input logic [2:0] f);
      repl_t r;
      case (f)
         3'b010:  r = REPL_B;
         3'b100:  r = REPL_C;
         default: r = REPL_A;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tmr_word_voter.sv
// Combinational bitwise majority voter over three replica words.
// Also flags every replica that differs from the voted word.
module tmr_word_voter
   import tmr_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int VoterType = VOTER_BN
) (
   input  logic [DataWidth-1:0] a,
   input  logic [DataWidth-1:0] b,
   input  logic [DataWidth-1:0] c,
   output logic [DataWidth-1:0] maj,
   output logic [2:0]           mismatch
);

   logic [DataWidth-1:0] ab_diff;

   assign ab_diff = a ^ b;

   generate
      if (VoterType == VOTER_KP) begin : g_kp
         assign maj = (ab_diff & c) | (~ab_diff & a);
      end else if (VoterType == VOTER_BN) begin : g_bn
         assign maj = (a & b) | (ab_diff & c);
      end else begin : g_ao
         assign maj = (a & b) | (a & c) | (b & c);
      end
   endgenerate

   assign mismatch = {
      |(c ^ maj),
      |(b ^ maj),
      |(a ^ maj)
   };

endmodule

// File: rtl/tmr_resync_ctrl.sv
// Registered TMR voter with fault counters, resync handshake
// and a sticky fatal state.
module tmr_resync_ctrl
   import tmr_pkg::*;
#(
   parameter int DataWidth     = 32,
   parameter int VoterType     = 2,
   parameter int CntWidth      = 8,
   parameter int TimeoutCycles = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic [DataWidth-1:0]  data_a_i,
   input  logic [DataWidth-1:0]  data_b_i,
   input  logic [DataWidth-1:0]  data_c_i,
   input  logic                  clear_i,
   output logic [DataWidth-1:0]  data_o,
   output logic                  valid_o,
   output logic [2:0]            mismatch_o,
   output logic                  resync_req_o,
   output logic [1:0]            resync_replica_o,
   input  logic                  resync_ack_i,
   output logic [3*CntWidth-1:0] fault_cnt_o,
   output logic                  fatal_o
);

   localparam int WaitW =
      (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   logic [DataWidth-1:0]       maj;
   logic [2:0]                 mm;
   logic [2:0]                 flags;
   logic                       multi;
   logic                       single;
   logic                       timeout_hit;
   state_e                     state_q, state_d;
   repl_t                      repl_q, repl_d;
   logic [WaitW-1:0]           wait_q, wait_d;
   logic [2:0][CntWidth-1:0]   cnt_q;

   tmr_word_voter #(
      .DataWidth (DataWidth),
      .VoterType (VoterType)
   ) u_voter (
      .a        (data_a_i),
      .b        (data_b_i),
      .c        (data_c_i),
      .maj      (maj),
      .mismatch (mm)
   );

   assign flags  = valid_i ? mm : 3'b000;
   assign multi  = (flags[0] & flags[1]) |
                   (flags[0] & flags[2]) |
                   (flags[1] & flags[2]);
   assign single = (|flags) & ~multi;

   // Wait counter holds k during the k-th request cycle (0-based).
   assign timeout_hit = (TimeoutCycles != 0) &&
      (wait_q == WaitW'(TimeoutCycles - 1));

   always_comb begin
      state_d = state_q;
      repl_d  = repl_q;
      wait_d  = wait_q;
      if (clear_i) begin
         state_d = IDLE;
         wait_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (multi) begin
                  state_d = FATAL;
               end else if (single) begin
                  state_d = REQ;
                  repl_d  = flag_idx(flags);
                  wait_d  = '0;
               end
            end
            REQ: begin
               if (multi) begin
                  state_d = FATAL;
               end else if (resync_ack_i) begin
                  state_d = IDLE;
               end else if (timeout_hit) begin
                  state_d = FATAL;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            FATAL: state_d = FATAL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         repl_q     <= REPL_A;
         wait_q     <= '0;
         data_o     <= '0;
         valid_o    <= 1'b0;
         mismatch_o <= 3'b000;
      end else begin
         state_q    <= state_d;
         repl_q     <= repl_d;
         wait_q     <= wait_d;
         data_o     <= maj;
         valid_o    <= valid_i;
         mismatch_o <= flags;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (clear_i) begin
               cnt_q[i] <= '0;
            end else if (flags[i] && !(&cnt_q[i])) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign fault_cnt_o      = cnt_q;
   assign resync_req_o     = (state_q == REQ);
   assign resync_replica_o = repl_q;
   assign fatal_o          = (state_q == FATAL);

endmodule

// File: doc/tmr_resync_ctrl.md
# tmr_resync_ctrl

- Sits at the output of a triplicated datapath.
- Votes three DataWidth-wide replica words into one registered majority word and identifies which replica disagrees.
- Keeps per-replica saturating fault counters.
- Drives a req/ack resynchronisation handshake toward the faulty replica.
- Escalates to a sticky fatal state on multi-replica disagreement or an unanswered resync request.

## Interface
Parameters:
- DataWidth, 32, width of each replica word
- VoterType, 2, per-bit majority implementation: 0 classical AND/OR, 1 KP, 2 BN; any other value behaves as 0
- CntWidth, 8, width of each fault counter
- TimeoutCycles, 64, max cycles resync_req_o may wait for ack; 0 disables the timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low (fixed: one clock, async active-low reset)
- valid_i  in  1  replica words valid this cycle
- data_a_i / data_b_i / data_c_i  in  DataWidth  replica words A, B, C
- clear_i  in  1  synchronous clear of counters, fatal state and FSM
- data_o  out  DataWidth  registered majority word
- valid_o  out  1  registered valid_i
- mismatch_o  out  3  registered per-replica disagree flags, bit0 = A, bit1 = B, bit2 = C
- resync_req_o  out  1  resync request
- resync_replica_o  out  2  replica to resync: 0 = A, 1 = B, 2 = C
- resync_ack_i  in  1  resync acknowledge
- fault_cnt_o  out  3 x CntWidth  saturating per-replica fault counts
- fatal_o  out  1  sticky unrecoverable-fault flag

## Operation
- Majority is computed bitwise.
- Replica X mismatches if any bit of X differs from the majority.
- Mismatch flags are evaluated only when valid_i = 1; otherwise they are 0.
- Counters: on every valid cycle, each mismatching replica's counter increments and saturates at 2^CntWidth-1. This applies in every FSM state.
- FSM states: IDLE, REQ, FATAL.
  - IDLE, exactly one flag set: latch the replica index, go to REQ.
  - IDLE, two or more flags set: go to FATAL.
  - IDLE, no flags set: stay in IDLE.
  - REQ, resync_ack_i = 1: go to IDLE.
  - REQ, wait counter reaches TimeoutCycles (TimeoutCycles ≠ 0): go to FATAL.
  - REQ, two or more flags set: go to FATAL.
  - REQ, single-replica mismatches: counted only; no new request is queued.
  - FATAL: absorbing. Only clear_i or reset leaves it.
- clear_i has top priority:
  - next state is IDLE, the request is dropped, and counters, the wait counter and fatal_o go to 0;
  - increments in the same cycle are discarded.
- resync_replica_o is stable while resync_req_o = 1.
- In IDLE and FATAL it holds the last latched value.
- fatal_o = (state == FATAL).

## Timing
- Reset values:
  - data_o = 0, valid_o = 0, mismatch_o = 0;
  - resync_req_o = 0, resync_replica_o = 0;
  - fault_cnt_o = 0, fatal_o = 0;
  - state = IDLE.
- Latency: data_o, valid_o, mismatch_o and the counter update appear 1 cycle after the input cycle.
- resync_req_o and fatal_o rise in that same cycle, since all are registered off the same edge.
- The request handshake:
  - ack is sampled only while resync_req_o = 1, and ack with the request low is ignored;
  - ack in the first cycle of the request is accepted;
  - the request drops the cycle after ack is seen;
  - a new request can rise at the earliest 1 cycle after the drop.
- Timeout: the wait counter starts at 0 on entry to REQ. With no ack, the FATAL transition is registered at the end of the request's TimeoutCycles-th cycle. The request is therefore high for exactly TimeoutCycles cycles.
- Ack and timeout in the same cycle: ack wins.
- Reset mid-request drops resync_req_o immediately (asynchronous).

## Structure
- Shared package tmr_pkg:
  - state enum {IDLE, REQ, FATAL};
  - replica index typedef (2 bits) with constants REPL_A = 0, REPL_B = 1, REPL_C = 2;
  - voter-type constants.
- Sub-module tmr_word_voter:
  - purely combinational, parameterised by DataWidth and VoterType;
  - outputs the majority word and the 3-bit mismatch vector.
- The top level holds the registers, counters and FSM.

## Test plan
- Reset then idle inputs A = B = C = 0x0000_0000, valid_i = 1:
  - data_o = 0, mismatch_o = 0, resync_req_o = 0;
  - all counters stay 0.
- Single fault: A = B = 0xDEAD_BEEF, C = 0xDEAD_BEEE for 1 cycle. Next cycle:
  - data_o = 0xDEAD_BEEF, mismatch_o = 3'b100;
  - fault_cnt C = 1;
  - resync_req_o = 1, resync_replica_o = 2.
  - Then ack held 1 cycle 3 cycles later → the request drops the following cycle.
- Multi-replica fault: A = 0x1, B = 0x2, C = 0x3 → data_o = 0x3, mismatch_o = 3'b011, fatal_o = 1 next cycle. fatal_o holds until clear_i is pulsed.
- Timeout: TimeoutCycles = 4, single fault on B, ack never asserted → request high exactly 4 cycles, then fatal_o = 1.
- Saturation/clear:
  - CntWidth = 2 with 5 consecutive faults on A → count A = 3;
  - clear_i together with a fault on A → count A = 0 next cycle and state = IDLE.
- Invalid input: a mismatching triple with valid_i = 0 → no counter change, mismatch_o = 0, no request.
